// File: rtl/bcd_inc_scheduler.sv
// BCD event counter fed by SOURCES sticky increment requesters; source i adds 10^i.
// One granted add at a time, rippling the carry one digit per cycle.
module bcd_inc_scheduler #(
  parameter int DIGITS  = 8,
  parameter int SOURCES = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  pause,
  input  logic [SOURCES-1:0]    req,
  output logic [4*DIGITS-1:0]   value,
  output logic                  busy,
  output logic [SOURCES-1:0]    grant,
  output logic                  done,
  output logic                  wrap,
  output logic                  drop
);

  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {IDLE, ADD} state_t;

  state_t               state;
  logic [SOURCES-1:0]   pending;
  logic [SOURCES-1:0]   req_eff;
  logic [PW-1:0]        pos;
  logic [PW-1:0]        gidx;
  logic                 carry;
  logic [3:0]           cur;
  logic                 cur_nine;
  logic                 last;

  // Grant/done/wrap/drop decode the registered state directly so the grant
  // cycle precedes ADD and done marks the final ADD cycle itself.
  always_comb begin
    req_eff    = req;
    req_eff[0] = req[0] & ~pause;
    grant      = '0;
    gidx       = '0;
    if (state == IDLE && !clear) begin
      for (int i = SOURCES - 1; i >= 0; i--) begin
        if (pending[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
          gidx     = PW'(i);
        end
      end
    end
  end

  assign cur      = value[4*int'(pos) +: 4];
  assign cur_nine = carry && (cur == 4'd9);
  assign last     = (pos == PW'(DIGITS - 1));
  assign busy     = (state == ADD);
  assign done     = busy && !clear && (!cur_nine || last);
  assign wrap     = busy && !clear && cur_nine && last;
  // A request for a source granted this very cycle re-arms pending, not a drop.
  assign drop     = !clear && |(req_eff & pending & ~grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      value   <= '0;
      pos     <= '0;
      carry   <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      pending <= '0;
      value   <= '0;
      pos     <= '0;
      carry   <= 1'b0;
    end else begin
      pending <= (pending & ~grant) | req_eff;
      case (state)
        IDLE: begin
          if (|grant) begin
            state <= ADD;
            pos   <= gidx;
            carry <= 1'b1;
          end
        end
        ADD: begin
          value[4*int'(pos) +: 4] <= cur_nine ? 4'd0 : cur + {3'b000, carry};
          if (done) begin
            state <= IDLE;
            carry <= 1'b0;
          end else begin
            pos <= pos + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
